// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - CPU-side INTA# pulse train generator and vector capture for an 8259A
module pic_inta_sequencer #(
    parameter int         INTA_LOW_CYCLES = 2,
    parameter int         INTA_GAP_CYCLES = 2,
    parameter logic [7:0] CALL_OPCODE     = 8'hCD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_enable,
    input  logic        interrupt_to_cpu,
    input  logic        u8086_or_mcs80,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        vector_valid,
    input  logic        vector_accept,
    output logic [7:0]  vector_8086,
    output logic [15:0] call_address,
    output logic        opcode_error,
    output logic        busy
);

    localparam int MAX_CYCLES = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cycle_q, cycle_d;
    logic [1:0]      pulse_q, pulse_d;
    logic            mode_q, mode_d;
    logic            capture;
    logic            last_pulse;
    logic            inta_n_q;
    logic [7:0]      byte1_q, byte2_q;
    logic [7:0]      vector_q;
    logic [15:0]     call_q;
    logic            error_q;

    // mode_q = 1 selects the two-pulse 8086 sequence
    assign last_pulse = mode_q ? (pulse_q == 2'd2) : (pulse_q == 2'd3);

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        pulse_d = pulse_q;
        mode_d  = mode_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (interrupt_enable && interrupt_to_cpu) begin
                    mode_d  = u8086_or_mcs80;
                    pulse_d = 2'd1;
                    cycle_d = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cycle_q == LOW_LAST) begin
                    capture = 1'b1;
                    cycle_d = '0;
                    state_d = last_pulse ? HOLD : GAP;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            GAP: begin
                if (cycle_q == GAP_LAST) begin
                    cycle_d = '0;
                    pulse_d = pulse_q + 2'd1;
                    state_d = LOW;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            HOLD: begin
                if (vector_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cycle_q  <= '0;
            pulse_q  <= '0;
            mode_q   <= 1'b0;
            inta_n_q <= 1'b1;
            byte1_q  <= '0;
            byte2_q  <= '0;
            vector_q <= '0;
            call_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            pulse_q  <= pulse_d;
            mode_q   <= mode_d;
            // INTA# comes straight from a flop so the PIC never sees a glitch
            inta_n_q <= (state_d != LOW);
            if (capture) begin
                if (pulse_q == 2'd1) begin
                    byte1_q <= data_bus_in;
                end
                if (pulse_q == 2'd2) begin
                    byte2_q <= data_bus_in;
                end
                if (last_pulse) begin
                    if (mode_q) begin
                        vector_q <= data_bus_in;
                        call_q   <= '0;
                        error_q  <= 1'b0;
                    end else begin
                        vector_q <= '0;
                        call_q   <= {data_bus_in, byte2_q};
                        error_q  <= (byte1_q != CALL_OPCODE);
                    end
                end
            end
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector_valid            = (state_q == HOLD);
    assign busy                    = (state_q != IDLE);
    assign vector_8086             = vector_q;
    assign call_address            = call_q;
    assign opcode_error            = error_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - scoreboard bench for pic_inta_sequencer
module tb_pic_inta_sequencer;

    localparam int L = 2;
    localparam int G = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt_enable = 1'b0;
    logic        interrupt_to_cpu = 1'b0;
    logic        u8086_or_mcs80 = 1'b1;
    logic [7:0]  data_bus_in = 8'hA5;
    logic        interrupt_acknowledge_n;
    logic        vector_valid;
    logic        vector_accept = 1'b0;
    logic [7:0]  vector_8086;
    logic [15:0] call_address;
    logic        opcode_error;
    logic        busy;

    pic_inta_sequencer #(
        .INTA_LOW_CYCLES(L),
        .INTA_GAP_CYCLES(G),
        .CALL_OPCODE(8'hCD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .interrupt_enable(interrupt_enable),
        .interrupt_to_cpu(interrupt_to_cpu),
        .u8086_or_mcs80(u8086_or_mcs80),
        .data_bus_in(data_bus_in),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .vector_valid(vector_valid),
        .vector_accept(vector_accept),
        .vector_8086(vector_8086),
        .call_address(call_address),
        .opcode_error(opcode_error),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic [7:0]  vec;
        logic [15:0] call;
        logic        err;
        int          at;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // PIC model: drives the byte for the current INTA# pulse
    logic [7:0] pb [1:3];
    int pcount = 0;
    logic inta_prev = 1'b1;

    always @(negedge clock) begin
        if (interrupt_acknowledge_n == 1'b0) begin
            if (inta_prev) pcount = pcount + 1;
            data_bus_in = (pcount >= 1 && pcount <= 3) ? pb[pcount] : 8'h5A;
        end else begin
            data_bus_in = 8'hA5;
            if (!busy) pcount = 0;
        end
        inta_prev = interrupt_acknowledge_n;
    end

    // Monitor: checks each new result against the scoreboard head
    logic vv_prev = 1'b0;

    always @(negedge clock) begin
        if (!reset && vector_valid && !vv_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("vector_8086", {24'd0, vector_8086}, {24'd0, e.vec});
                chk("call_address", {16'd0, call_address}, {16'd0, e.call});
                chk("opcode_error", {31'd0, opcode_error}, {31'd0, e.err});
                chk("valid_latency", cyc, e.at);
            end
        end
        vv_prev = vector_valid;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inta_n"}, {31'd0, interrupt_acknowledge_n}, 32'd1);
        chk({tag, "_valid"}, {31'd0, vector_valid}, 32'd0);
        chk({tag, "_vec"}, {24'd0, vector_8086}, 32'd0);
        chk({tag, "_call"}, {16'd0, call_address}, 32'd0);
        chk({tag, "_err"}, {31'd0, opcode_error}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // started=1: INT was already sampled at the edge just before the current negedge
    task automatic run_seq(input logic m, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input int acc_delay, input bit keep_int, input bit started, input bit drop_int);
        int n, lat, per, t_low;
        exp_t e;
        logic exp_low;
        n = m ? 2 : 3;
        per = L + G;
        lat = n * L + (n - 1) * G + 1;
        pb[1] = b1;
        pb[2] = b2;
        pb[3] = b3;
        if (!started) begin
            u8086_or_mcs80 = m;
            interrupt_to_cpu = 1'b1;
            interrupt_enable = 1'b1;
            @(negedge clock);
        end
        e.vec = m ? b2 : 8'h00;
        e.call = m ? 16'h0000 : {b3, b2};
        e.err = m ? 1'b0 : (b1 != 8'hCD);
        e.at = cyc + lat - 1;
        sbq.push_back(e);
        for (int t = 0; t < lat - 1; t++) begin
            t_low = t % per;
            exp_low = (t_low < L);
            chk("inta_pattern", {31'd0, interrupt_acknowledge_n}, {31'd0, ~exp_low});
            chk("busy_seq", {31'd0, busy}, 32'd1);
            if (drop_int && t == 0) interrupt_to_cpu = 1'b0;
            @(negedge clock);
        end
        chk("inta_in_hold", {31'd0, interrupt_acknowledge_n}, 32'd1);
        for (int d = 0; d < acc_delay; d++) begin
            @(negedge clock);
            chk("hold_valid", {31'd0, vector_valid}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            chk("hold_vec", {24'd0, vector_8086}, {24'd0, e.vec});
            chk("hold_call", {16'd0, call_address}, {16'd0, e.call});
            chk("hold_err", {31'd0, opcode_error}, {31'd0, e.err});
        end
        if (!keep_int) interrupt_to_cpu = 1'b0;
        vector_accept = 1'b1;
        @(negedge clock);
        vector_accept = 1'b0;
        chk("idle_valid", {31'd0, vector_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_inta_n", {31'd0, interrupt_acknowledge_n}, 32'd1);
    endtask

    initial begin
        pb[1] = 8'h00;
        pb[2] = 8'h00;
        pb[3] = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 8086: vector 48
        run_seq(1'b1, 8'hFF, 8'h48, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        // MCS-80 CALL 1240, INT dropped during pulse 1
        run_seq(1'b0, 8'hCD, 8'h40, 8'h12, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        // MCS-80 with bad opcode
        run_seq(1'b0, 8'h00, 8'h34, 8'h12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        // late accept with INT held high: next sequence follows immediately
        run_seq(1'b1, 8'h11, 8'h9C, 8'h00, 5, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("rearm_inta_low", {31'd0, interrupt_acknowledge_n}, 32'd0);
        run_seq(1'b1, 8'h11, 8'h9C, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);

        // reset during the second LOW of an MCS-80 sequence
        pb[1] = 8'hCD;
        pb[2] = 8'h77;
        pb[3] = 8'h66;
        u8086_or_mcs80 = 1'b0;
        interrupt_to_cpu = 1'b1;
        interrupt_enable = 1'b1;
        @(negedge clock);
        repeat (L + G) @(negedge clock);
        chk("second_low_inta_n", {31'd0, interrupt_acknowledge_n}, 32'd0);
        interrupt_to_cpu = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            chk("post_reset_valid", {31'd0, vector_valid}, 32'd0);
        end

        // interrupts masked
        interrupt_enable = 1'b0;
        interrupt_to_cpu = 1'b1;
        u8086_or_mcs80 = 1'b1;
        pb[1] = 8'h22;
        pb[2] = 8'hE3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("masked_inta_n", {31'd0, interrupt_acknowledge_n}, 32'd1);
            chk("masked_busy", {31'd0, busy}, 32'd0);
        end
        interrupt_enable = 1'b1;
        @(negedge clock);
        chk("enable_inta_low", {31'd0, interrupt_acknowledge_n}, 32'd0);
        run_seq(1'b1, 8'h22, 8'hE3, 8'h00, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
